// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: bundle of the N_SRC source streams and the single sink
// stream around axis_rr_arbiter. M_TID widens by the source index when
// AXIS_ARB_ID_TAG_EN is defined.
//
// Handshake rule, all streams: a beat moves on a rising clock edge where
// TVALID and TREADY are both high. A source holds TVALID and its payload
// stable until that edge. TREADY may depend combinationally on TVALID.
//
// modport master : the arbiter's view. It drives the sink stream and S_TREADY.
// modport slave  : the environment's view. It drives the sources and M_TREADY.
interface axis_rr_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 1
);
  localparam int IDX_W  = $clog2(N_SRC);
  localparam int KEEP_W = DATA_W / 8;
`ifdef AXIS_ARB_ID_TAG_EN
  localparam int M_ID_W = ID_W + IDX_W;
`else
  localparam int M_ID_W = ID_W;
`endif

  logic [N_SRC-1:0]        S_TVALID;
  logic [N_SRC-1:0]        S_TREADY;
  logic [N_SRC*DATA_W-1:0] S_TDATA;
  logic [N_SRC*KEEP_W-1:0] S_TSTRB;
  logic [N_SRC*KEEP_W-1:0] S_TKEEP;
  logic [N_SRC-1:0]        S_TLAST;
  logic [N_SRC*ID_W-1:0]   S_TID;
  logic [N_SRC*DEST_W-1:0] S_TDEST;
  logic [N_SRC*USER_W-1:0] S_TUSER;

  logic                    M_TVALID;
  logic                    M_TREADY;
  logic [DATA_W-1:0]       M_TDATA;
  logic [KEEP_W-1:0]       M_TSTRB;
  logic [KEEP_W-1:0]       M_TKEEP;
  logic                    M_TLAST;
  logic [M_ID_W-1:0]       M_TID;
  logic [DEST_W-1:0]       M_TDEST;
  logic [USER_W-1:0]       M_TUSER;

  modport master (
    input  S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER,
    output S_TREADY,
    output M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER,
    input  M_TREADY
  );

  modport slave (
    output S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER,
    input  S_TREADY,
    input  M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER,
    output M_TREADY
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin, packet-locked arbiter sharing one AXI4-Stream
// sink among N_SRC sources. A grant is held until the granted source's TLAST
// beat is accepted, so packets never interleave. There is no beat storage:
// the payload and ready paths are pure muxes selected by the registered grant.
// Optional feature macro: AXIS_ARB_ID_TAG_EN prepends the grant index to M_TID.
module axis_rr_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  axis_rr_arbiter_if.master        bus,
  output logic                     GRANT_VALID,
  output logic [$clog2(N_SRC)-1:0] GRANT_IDX
);
  localparam int IDX_W  = $clog2(N_SRC);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   last_q;
  logic               grant_valid_q;

  logic [IDX_W-1:0]   pick_d;
  logic               any_req;

  logic               v_sel;
  logic [DATA_W-1:0]  data_sel;
  logic [KEEP_W-1:0]  strb_sel;
  logic [KEEP_W-1:0]  keep_sel;
  logic               last_sel;
  logic [ID_W-1:0]    tid_sel;
  logic [DEST_W-1:0]  dest_sel;
  logic [USER_W-1:0]  user_sel;
  logic               m_tvalid;
  logic [N_SRC-1:0]   s_tready;

  // Round-robin pick: first requester searching upward from last_q+1, wrapping.
  always_comb begin
    pick_d  = grant_q;
    any_req = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N_SRC;
      if (!any_req && bus.S_TVALID[idx]) begin
        any_req = 1'b1;
        pick_d  = IDX_W'(idx);
      end
    end
  end

  // Payload mux: every sink field comes from the slice of the granted source.
  always_comb begin
    v_sel    = 1'b0;
    data_sel = '0;
    strb_sel = '0;
    keep_sel = '0;
    last_sel = 1'b0;
    tid_sel  = '0;
    dest_sel = '0;
    user_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        v_sel    = bus.S_TVALID[i];
        data_sel = bus.S_TDATA[i*DATA_W +: DATA_W];
        strb_sel = bus.S_TSTRB[i*KEEP_W +: KEEP_W];
        keep_sel = bus.S_TKEEP[i*KEEP_W +: KEEP_W];
        last_sel = bus.S_TLAST[i];
        tid_sel  = bus.S_TID[i*ID_W +: ID_W];
        dest_sel = bus.S_TDEST[i*DEST_W +: DEST_W];
        user_sel = bus.S_TUSER[i*USER_W +: USER_W];
      end
    end
  end

  // Ready steering: only the granted source sees the sink's TREADY, and only
  // while LOCKED; in IDLE nothing is accepted.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      s_tready[i] = (state_q == ST_LOCKED) && (grant_q == IDX_W'(i)) && bus.M_TREADY;
    end
  end

  assign m_tvalid     = (state_q == ST_LOCKED) && v_sel;

  assign bus.S_TREADY = s_tready;
  assign bus.M_TVALID = m_tvalid;
  assign bus.M_TDATA  = data_sel;
  assign bus.M_TSTRB  = strb_sel;
  assign bus.M_TKEEP  = keep_sel;
  assign bus.M_TLAST  = last_sel;
  assign bus.M_TDEST  = dest_sel;
  assign bus.M_TUSER  = user_sel;
`ifdef AXIS_ARB_ID_TAG_EN
  assign bus.M_TID    = {grant_q, tid_sel};
`else
  assign bus.M_TID    = tid_sel;
`endif

  assign GRANT_VALID  = grant_valid_q;
  assign GRANT_IDX    = grant_q;

  // Arbitration FSM: lock onto the pick in IDLE, release on the TLAST handshake.
  // last_q resets to N_SRC-1 so source 0 is first in line after reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_q        <= IDX_W'(N_SRC - 1);
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q       <= pick_d;
            state_q       <= ST_LOCKED;
            grant_valid_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (m_tvalid && bus.M_TREADY && last_sel) begin
            last_q        <= grant_q;
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin, packet-locked arbiter that shares one AXI4-Stream sink among `N_SRC` AXI4-Stream sources. A grant, once issued, is held until the granted source's `TLAST` beat completes, so packets are never interleaved. The block sits between several stream producers and a single stream consumer. Both sides comply with the AXI4-Stream protocol checked by the `amba_axi4_stream_seda` VIP, which binds to the master port and to each slave port.

## Interface
- `N_SRC`, 4: number of slave (source) ports; legal range 2..16.
- `DATA_W`, 32: `TDATA` width in bits; must be a multiple of 8.
- `ID_W`, 4: `TID` width.
- `DEST_W`, 4: `TDEST` width.
- `USER_W`, 1: `TUSER` width.
- `IDX_W`: derived, not overridable; equals clog2(`N_SRC`).
- `ACLK`  in  1  clock; all logic is on the rising edge.
- `ARESETn`  in  1  reset, asynchronous assert, active-low.
- `S_TVALID`  in  N_SRC  per-source valid.
- `S_TREADY`  out  N_SRC  per-source ready.
- `S_TDATA`  in  N_SRC*DATA_W  packed data; source i occupies slice i.
- `S_TSTRB`, `S_TKEEP`  in  N_SRC*DATA_W/8 each  packed strobes.
- `S_TLAST`  in  N_SRC  packet end.
- `S_TID`  in  N_SRC*ID_W; `S_TDEST`  in  N_SRC*DEST_W; `S_TUSER`  in  N_SRC*USER_W.
- `M_TVALID`  out  1; `M_TREADY`  in  1.
- `M_TDATA`, `M_TSTRB`, `M_TKEEP`, `M_TLAST`, `M_TDEST`, `M_TUSER`  out  same widths as one source slice.
- `M_TID`  out  ID_W (ID_W+IDX_W with `AXIS_ARB_ID_TAG_EN`).
- `GRANT_VALID`  out  1  arbiter is in LOCKED.
- `GRANT_IDX`  out  IDX_W  currently or most recently granted source.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE behaviour:
  - `M_TVALID`=0 and all `S_TREADY`=0.
  - If any `S_TVALID` is high, pick the first requester searching upward from `last+1` modulo `N_SRC`.
  - Register the pick into `grant` and move to LOCKED.
- LOCKED behaviour:
  - `M_TVALID` = `S_TVALID[grant]`; all M payload comes from slice `grant`.
  - `S_TREADY[grant]` = `M_TREADY`; every other `S_TREADY` is 0.
- A handshake is `M_TVALID && M_TREADY`.
  - On a handshake with `M_TLAST`=1: set `last`<=`grant` and return to IDLE.
  - On a handshake with `M_TLAST`=0: stay in LOCKED.
- Requests from non-granted sources are ignored while LOCKED. Their VALID stays pending under the protocol, and they are not starved: rotation guarantees service within `N_SRC`-1 packets.
- Paths from `M_TREADY` to `S_TREADY` and from the source to M are combinational. There is no storage of beats.
- The granted source may drop `TVALID` only between beats (protocol-legal idle). The arbiter stays LOCKED through such gaps.

## Timing
- Reset (ARESETn=0, asynchronous):
  - state=IDLE, `last`=N_SRC-1 (source 0 wins first), `grant`=0.
  - `M_TVALID`=0, `S_TREADY`=0, `GRANT_VALID`=0, `GRANT_IDX`=0.
  - Deassertion is synchronised externally.
- Arbitration latency: a request seen in IDLE at cycle t has its first beat presentable at cycle t+1.
- Back-to-back packets have a one-cycle bubble: cycle t = TLAST handshake, cycle t+1 = IDLE, cycle t+2 = first beat of the next packet.
- Single-beat packet (`TLAST` on beat 0): LOCKED lasts exactly one cycle when `M_TREADY`=1.
- `M_TREADY` held low: the arbiter stays LOCKED indefinitely and no beat is lost or duplicated.
- Reset mid-packet: immediate return to IDLE. The partial packet is abandoned with no `TLAST` emitted, and `last` resets.
- Simultaneous requests in IDLE: the round-robin pointer decides; a fixed index never wins by default.
- `GRANT_VALID`/`GRANT_IDX` change only on the clock edge that enters or leaves LOCKED.

## Configuration
- Macro: `AXIS_ARB_ID_TAG_EN`.
- Defined:
  - `M_TID` = {`grant`, `S_TID[grant]`}, width ID_W+IDX_W.
  - The sink can route responses back by source index.
- Undefined: `M_TID` = `S_TID[grant]`, width ID_W. Identical in all other respects.

## Test plan
- Only source 2 sends a 3-beat packet (D=0xA0,0xA1,0xA2, TLAST on 0xA2) with `M_TREADY`=1 -> one IDLE cycle, then 3 M beats in order, `GRANT_IDX`=2, back to IDLE.
- Sources 0 and 1 both request right after reset, 2-beat packets each -> source 0 packet completes first, one bubble cycle, then source 1; no interleaving.
- All 4 sources request continuously, 1-beat packets -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Source 3 packet in progress with `M_TREADY` toggling 1,0,0,1 -> `S_TREADY[3]` mirrors `M_TREADY`; sources 0–2 see `S_TREADY`=0; exactly 2 beats transferred.
- ARESETn pulsed low after beat 1 of a 4-beat packet from source 1 -> `M_TVALID` drops asynchronously; after release source 0 (pending) wins first.
- With `AXIS_ARB_ID_TAG_EN`, source 2 sends TID=0x5 -> `M_TID`=0x25 (6 bits); without the macro -> `M_TID`=0x5.
